// File: rtl/awgn_sched_if.sv
// Noise grant bus between the awgn scheduler and its channel datapaths.
// The scheduler is the master; the channel side drives requests.
interface awgn_sched_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic              noise_valid;
    logic [15:0]       noise_data;
    logic [CH_W-1:0]   noise_ch;

    modport master (
        input  req,
        output gnt,
        output noise_valid,
        output noise_data,
        output noise_ch
    );

    modport slave (
        output req,
        input  gnt,
        input  noise_valid,
        input  noise_data,
        input  noise_ch
    );
endinterface

// File: rtl/awgn_sched.sv
// Shares one awgn generator among NUM_CH consumers: seeds it, waits out
// warm-up, then round-robin grants one noise sample per cycle.
module awgn_sched #(
    parameter int NUM_CH = 4,
    parameter int WARMUP = 8,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [15:0]       cfg_seed,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              gen_enable,
    output logic [15:0]       gen_seed,
    input  logic [15:0]       gen_wnoise,
    awgn_sched_if.master      bus,
    output logic              busy,
    output logic              ready
);

    typedef enum logic [2:0] {
        IDLE,
        REARM,
        LOAD,
        WARM,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [7:0]        warm_cnt;
    logic [7:0]        warm_nx;
    logic              seed_ld;

    logic [CH_W-1:0]   rr_last;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] gnt_w;
    logic [CH_W-1:0]   win;
    logic [CH_W-1:0]   cand;
    logic              hit;

    logic              nv_q;
    logic [15:0]       nd_q;
    logic [CH_W-1:0]   nc_q;

    // Next-state: stop dominates; start re-seeds and forces a fresh enable edge.
    always_comb begin
        state_nx = state;
        warm_nx  = warm_cnt;
        seed_ld  = 1'b0;
        if (cfg_stop) begin
            state_nx = IDLE;
        end else begin
            seed_ld = cfg_start;
            unique case (state)
                IDLE: begin
                    if (cfg_start) state_nx = LOAD;
                end
                REARM: begin
                    state_nx = LOAD;
                end
                LOAD: begin
                    state_nx = WARM;
                    warm_nx  = 8'(WARMUP - 1);
                end
                WARM: begin
                    if (cfg_start)
                        state_nx = REARM;
                    else if (warm_cnt == 8'd0)
                        state_nx = RUN;
                    else
                        warm_nx = warm_cnt - 8'd1;
                end
                RUN: begin
                    if (cfg_start) state_nx = REARM;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Sequencer state with registered status and generator controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            warm_cnt   <= 8'd0;
            gen_seed   <= 16'd0;
            gen_enable <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state      <= state_nx;
            warm_cnt   <= warm_nx;
            if (seed_ld) gen_seed <= cfg_seed;
            gen_enable <= (state_nx == LOAD) || (state_nx == WARM) ||
                          (state_nx == RUN);
            busy       <= (state_nx != IDLE);
            ready      <= (state_nx == RUN);
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        eligible = bus.req & ch_mask;
        gnt_w    = '0;
        win      = '0;
        cand     = '0;
        hit      = 1'b0;
        if (state == RUN) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = CH_W'((int'(rr_last) + k) % NUM_CH);
                if (!hit && eligible[cand]) begin
                    hit = 1'b1;
                    win = cand;
                end
            end
        end
        if (hit) gnt_w[win] = 1'b1;
    end

    // Capture the sample of the grant cycle; data and channel hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= CH_W'(NUM_CH - 1);
            nv_q    <= 1'b0;
            nd_q    <= 16'd0;
            nc_q    <= '0;
        end else begin
            nv_q <= hit;
            if (hit) begin
                rr_last <= win;
                nd_q    <= gen_wnoise;
                nc_q    <= win;
            end
        end
    end

    assign bus.gnt         = gnt_w;
    assign bus.noise_valid = nv_q;
    assign bus.noise_data  = nd_q;
    assign bus.noise_ch    = nc_q;

endmodule

// File: tb/tb_awgn_sched.sv
// Self-checking bench for awgn_sched: reference model plus sample
// scoreboard, with directed sequencing scenarios.
module tb_awgn_sched;

    localparam int NUM_CH = 4;
    localparam int WARMUP = 8;
    localparam int CH_W   = 2;

    localparam int S_IDLE  = 0;
    localparam int S_REARM = 1;
    localparam int S_LOAD  = 2;
    localparam int S_WARM  = 3;
    localparam int S_RUN   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [15:0] cfg_seed = 16'd0;
    logic [3:0]  ch_mask = 4'hF;
    logic        gen_enable;
    logic [15:0] gen_seed;
    logic [15:0] gen_wnoise = 16'd0;
    logic        busy;
    logic        ready;

    awgn_sched_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    awgn_sched #(
        .NUM_CH(NUM_CH),
        .WARMUP(WARMUP),
        .CH_W  (CH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_seed  (cfg_seed),
        .ch_mask   (ch_mask),
        .gen_enable(gen_enable),
        .gen_seed  (gen_seed),
        .gen_wnoise(gen_wnoise),
        .bus       (bus),
        .busy      (busy),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    int          m_state = S_IDLE;
    int          m_cnt   = 0;
    int          m_rr    = NUM_CH - 1;
    logic [15:0] m_seed  = 16'd0;
    logic [17:0] last_s  = 18'd0;
    logic [17:0] sb[$];
    int          glog[$];
    bit          mon_en  = 1'b0;

    logic [3:0]  elig;
    logic [3:0]  eg;
    logic [17:0] e;
    int          w;
    int          c;
    int          gi;

    // Compare outputs against the model, then advance the model by one edge.
    always @(negedge clk) begin
        elig = bus.req & ch_mask;
        eg   = 4'd0;
        w    = -1;
        if (m_state == S_RUN) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                c = (m_rr + k) % NUM_CH;
                if (w < 0 && elig[c]) w = c;
            end
        end
        if (w >= 0) eg[w] = 1'b1;

        if (mon_en) begin
            check("gnt", {28'd0, bus.gnt}, {28'd0, eg});
            check("ready", {31'd0, ready}, {31'd0, m_state == S_RUN});
            check("busy", {31'd0, busy}, {31'd0, m_state != S_IDLE});
            check("gen_enable", {31'd0, gen_enable},
                  {31'd0, m_state == S_LOAD || m_state == S_WARM ||
                          m_state == S_RUN});
            check("gen_seed", {16'd0, gen_seed}, {16'd0, m_seed});
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("noise_valid", {31'd0, bus.noise_valid}, 32'd1);
                check("noise_data", {16'd0, bus.noise_data}, {16'd0, e[15:0]});
                check("noise_ch", {30'd0, bus.noise_ch}, {30'd0, e[17:16]});
                last_s = e;
            end else begin
                check("noise_idle", {31'd0, bus.noise_valid}, 32'd0);
                check("noise_hold_d", {16'd0, bus.noise_data},
                      {16'd0, last_s[15:0]});
                check("noise_hold_ch", {30'd0, bus.noise_ch},
                      {30'd0, last_s[17:16]});
            end
            if (bus.gnt != 4'd0) begin
                gi = 0;
                for (int k = NUM_CH - 1; k >= 0; k--)
                    if (bus.gnt[k]) gi = k;
                glog.push_back(gi);
            end
        end

        if (rst) begin
            sb.delete();
            last_s  = 18'd0;
            m_state = S_IDLE;
            m_cnt   = 0;
            m_rr    = NUM_CH - 1;
            m_seed  = 16'd0;
        end else begin
            if (w >= 0) begin
                sb.push_back({w[1:0], gen_wnoise});
                m_rr = w;
            end
            if (cfg_stop) begin
                m_state = S_IDLE;
            end else begin
                if (cfg_start) m_seed = cfg_seed;
                case (m_state)
                    S_IDLE:  if (cfg_start) m_state = S_LOAD;
                    S_REARM: m_state = S_LOAD;
                    S_LOAD: begin
                        m_state = S_WARM;
                        m_cnt   = WARMUP - 1;
                    end
                    S_WARM: begin
                        if (cfg_start) m_state = S_REARM;
                        else if (m_cnt == 0) m_state = S_RUN;
                        else m_cnt = m_cnt - 1;
                    end
                    S_RUN: if (cfg_start) m_state = S_REARM;
                    default: m_state = S_IDLE;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        gen_wnoise = 16'($urandom);
    endtask

    task automatic start(input logic [15:0] s);
        cfg_seed  = s;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;
    int ones;

    initial begin
        bus.req = 4'd0;
        tick();
        tick();
        mon_en = 1'b1;
        check("rst_seed", {16'd0, gen_seed}, 32'd0);
        check("rst_ndata", {16'd0, bus.noise_data}, 32'd0);
        check("rst_nch", {30'd0, bus.noise_ch}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // seed load and warm-up
        bus.req = 4'hF;
        start(16'h1234);
        check("seed_1234", {16'd0, gen_seed}, 32'h1234);
        check("load_en", {31'd0, gen_enable}, 32'd1);
        wait_ready(n);
        check("ready_lat", n, 9);

        // full round robin
        glog.delete();
        repeat (8) tick();
        bus.req = 4'd0;
        check("rr_cnt", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            check("rr_seq", glog[i], i % 4);
        tick();

        // masked channels
        glog.delete();
        ch_mask = 4'b0010;
        bus.req = 4'b1010;
        repeat (6) tick();
        bus.req = 4'd0;
        ch_mask = 4'hF;
        ones = 0;
        foreach (glog[i]) if (glog[i] == 1) ones++;
        check("mask_cnt", glog.size(), 6);
        check("mask_only1", ones, 6);

        // restart while running
        bus.req = 4'hF;
        start(16'hBEEF);
        check("rearm_en", {31'd0, gen_enable}, 32'd0);
        check("seed_beef", {16'd0, gen_seed}, 32'hBEEF);
        wait_ready(n);
        check("rearm_lat", n, 10);
        bus.req = 4'd0;
        tick();

        // start with stop in WARM
        start(16'h4321);
        tick();
        tick();
        cfg_seed  = 16'h5555;
        cfg_start = 1'b1;
        cfg_stop  = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_en", {31'd0, gen_enable}, 32'd0);
        check("stop_seed", {16'd0, gen_seed}, 32'h4321);
        tick();

        // reset with a grant outstanding
        start(16'h1234);
        wait_ready(n);
        check("ready_lat2", n, 9);
        bus.req = 4'hF;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'd0;
        check("rst_nvalid", {31'd0, bus.noise_valid}, 32'd0);
        check("rst_busy2", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        start(16'h0042);
        wait_ready(n);
        glog.delete();
        bus.req = 4'hF;
        tick();
        bus.req = 4'd0;
        check("rst_first", glog.size() > 0 ? glog[0] : 99, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
